// File: rtl/branch_predict_ctrl.sv
// Branch prediction / update controller sitting on the consumer side of the
// branch history cache. Fetch side: a PHT of 2-bit counters indexed by the
// cache-supplied history produces the prediction. Execute side: an in-order
// queue of predicted branches is retired on resolve, updating the PHT and
// issuing a registered cache write plus mispredict/redirect.
module branch_predict_ctrl #(
    parameter int DEPTH      = 4,
    parameter int PC_WIDTH   = 10,
    parameter int HIST_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fetch_valid,
    input  logic [PC_WIDTH-1:0]         fetch_pc,
    input  logic                        fetch_is_branch,
    input  logic [PC_WIDTH-1:0]         fetch_target,
    output logic                        pred_taken,
    output logic [PC_WIDTH-1:0]         pred_pc,
    output logic                        stall,
    output logic [PC_WIDTH-1:0]         cache_pc,
    input  logic [HIST_WIDTH-1:0]       cache_read_history,
    input  logic                        cache_read_hit,
    input  logic                        resolve_valid,
    input  logic                        resolve_taken,
    output logic                        cache_we,
    output logic [PC_WIDTH-1:0]         cache_update_pc,
    output logic                        cache_branch_taken,
    output logic                        mispredict,
    output logic [PC_WIDTH-1:0]         redirect_pc,
    output logic [$clog2(DEPTH):0]      queue_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PHT_N = 1 << HIST_WIDTH;

    // Saturating 2-bit counter step toward the observed outcome.
    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        if (up) begin
            return (c == 2'b11) ? c : c + 2'd1;
        end
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Queue payload (not reset: only meaningful between head and tail).
    logic [PC_WIDTH-1:0]   pc_q   [DEPTH];
    logic [PC_WIDTH-1:0]   tgt_q  [DEPTH];
    logic [HIST_WIDTH-1:0] hist_q [DEPTH];
    logic                  hit_q  [DEPTH];
    logic                  pt_q   [DEPTH];

    // Control state.
    logic [PTR_W-1:0]      head_q, tail_q;
    logic [CNT_W-1:0]      count_q;
    logic [1:0]            pht_q [PHT_N];
    logic                  cache_we_q, cache_branch_taken_q, mispredict_q;
    logic [PC_WIDTH-1:0]   cache_update_pc_q, redirect_pc_q;

    logic                  br, full, push, pop, flush;
    logic [PC_WIDTH-1:0]   redirect_d;

    // Fetch-side prediction and queue handshake decode.
    always_comb begin
        br         = fetch_valid & fetch_is_branch;
        full       = (count_q == CNT_W'(DEPTH));
        stall      = br & full;
        push       = br & ~full;
        pop        = resolve_valid & (count_q != '0);
        pred_taken = br & cache_read_hit & pht_q[cache_read_history][1];
        pred_pc    = pred_taken ? fetch_target : fetch_pc + PC_WIDTH'(1);
        cache_pc   = fetch_pc;
        flush      = pop & (pt_q[head_q] != resolve_taken);
        redirect_d = resolve_taken ? tgt_q[head_q] : pc_q[head_q] + PC_WIDTH'(1);
    end

    // Pointers, count, PHT training and registered cache/pipeline outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q               <= '0;
            tail_q               <= '0;
            count_q              <= '0;
            cache_we_q           <= 1'b0;
            cache_branch_taken_q <= 1'b0;
            mispredict_q         <= 1'b0;
            cache_update_pc_q    <= '0;
            redirect_pc_q        <= '0;
            for (int i = 0; i < PHT_N; i++) begin
                pht_q[i] <= 2'b01;
            end
        end else begin
            cache_we_q           <= pop;
            cache_branch_taken_q <= pop & resolve_taken;
            mispredict_q         <= flush;
            if (pop) begin
                cache_update_pc_q <= pc_q[head_q];
                redirect_pc_q     <= redirect_d;
                if (hit_q[head_q]) begin
                    pht_q[hist_q[head_q]] <= sat_step(pht_q[hist_q[head_q]], resolve_taken);
                end
            end
            // A mispredict squashes every younger entry, including a same-cycle push.
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) tail_q <= tail_q + PTR_W'(1);
                if (pop)  head_q <= head_q + PTR_W'(1);
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Capture the fetched branch into the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail_q]   <= fetch_pc;
            tgt_q[tail_q]  <= fetch_target;
            hist_q[tail_q] <= cache_read_history;
            hit_q[tail_q]  <= cache_read_hit;
            pt_q[tail_q]   <= pred_taken;
        end
    end

    assign cache_we           = cache_we_q;
    assign cache_update_pc    = cache_update_pc_q;
    assign cache_branch_taken = cache_branch_taken_q;
    assign mispredict         = mispredict_q;
    assign redirect_pc        = redirect_pc_q;
    assign queue_count        = count_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with hand-computed expectations.
module tb_branch_predict_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_valid, fetch_is_branch;
    logic [9:0] fetch_pc, fetch_target;
    logic       pred_taken, stall;
    logic [9:0] pred_pc, cache_pc;
    logic [2:0] cache_read_history;
    logic       cache_read_hit;
    logic       resolve_valid, resolve_taken;
    logic       cache_we, cache_branch_taken, mispredict;
    logic [9:0] cache_update_pc, redirect_pc;
    logic [2:0] queue_count;

    int n_cmp = 0;
    int n_bad = 0;

    branch_predict_ctrl #(.DEPTH(4), .PC_WIDTH(10), .HIST_WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_is_branch(fetch_is_branch), .fetch_target(fetch_target),
        .pred_taken(pred_taken), .pred_pc(pred_pc), .stall(stall),
        .cache_pc(cache_pc), .cache_read_history(cache_read_history),
        .cache_read_hit(cache_read_hit),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .cache_we(cache_we), .cache_update_pc(cache_update_pc),
        .cache_branch_taken(cache_branch_taken), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a fetch; leaves a settle delay so combinational outputs can be sampled.
    task automatic fetch(input logic [9:0] pc, input logic [9:0] tgt,
                         input logic [2:0] hist, input logic hit);
        fetch_valid        = 1'b1;
        fetch_is_branch    = 1'b1;
        fetch_pc           = pc;
        fetch_target       = tgt;
        cache_read_history = hist;
        cache_read_hit     = hit;
        #1;
    endtask

    task automatic fetch_off();
        fetch_valid     = 1'b0;
        fetch_is_branch = 1'b0;
    endtask

    task automatic resolve(input logic tk);
        resolve_valid = 1'b1;
        resolve_taken = tk;
        tick();
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
    endtask

    task automatic check_retire(input string tag, input logic [9:0] upc,
                                input logic tk, input logic mp, input logic [9:0] rpc);
        check({tag, "_we"},  32'(cache_we), 32'd1);
        check({tag, "_upc"}, 32'(cache_update_pc), 32'(upc));
        check({tag, "_tk"},  32'(cache_branch_taken), 32'(tk));
        check({tag, "_mp"},  32'(mispredict), 32'(mp));
        if (mp || upc != 10'h000) check({tag, "_rpc"}, 32'(redirect_pc), 32'(rpc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        fetch_off();
        fetch_pc = '0; fetch_target = '0;
        cache_read_history = '0; cache_read_hit = 1'b0;
        resolve_valid = 1'b0; resolve_taken = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_cnt", 32'(queue_count), 32'd0);
        check("rst_we",  32'(cache_we), 32'd0);
        check("rst_mp",  32'(mispredict), 32'd0);
        check("rst_upc", 32'(cache_update_pc), 32'd0);
        check("rst_rpc", 32'(redirect_pc), 32'd0);
        check("rst_btk", 32'(cache_branch_taken), 32'd0);

        // First branch: weakly not-taken
        fetch(10'h010, 10'h080, 3'b000, 1'b1);
        check("f1_pt",    32'(pred_taken), 32'd0);
        check("f1_ppc",   32'(pred_pc), 32'h011);
        check("f1_cpc",   32'(cache_pc), 32'h010);
        check("f1_stall", 32'(stall), 32'd0);
        tick(); fetch_off();
        check("f1_cnt", 32'(queue_count), 32'd1);

        // Train PHT[0] taken three times: 01 -> 10 -> 11 -> 11
        resolve(1'b1);
        check_retire("r1", 10'h010, 1'b1, 1'b1, 10'h080);
        check("r1_cnt", 32'(queue_count), 32'd0);
        fetch(10'h010, 10'h080, 3'b000, 1'b1);
        check("f2_pt", 32'(pred_taken), 32'd1);
        tick(); fetch_off();
        resolve(1'b1);
        check_retire("r2", 10'h010, 1'b1, 1'b0, 10'h080);
        fetch(10'h010, 10'h080, 3'b000, 1'b1);
        tick(); fetch_off();
        resolve(1'b1);
        check_retire("r3", 10'h010, 1'b1, 1'b0, 10'h080);
        fetch(10'h010, 10'h080, 3'b000, 1'b1);
        check("f4_pt",  32'(pred_taken), 32'd1);
        check("f4_ppc", 32'(pred_pc), 32'h080);
        tick(); fetch_off();
        // One not-taken from a saturated 11 lands on 10: still predicts taken
        resolve(1'b0);
        check_retire("r4", 10'h010, 1'b0, 1'b1, 10'h011);
        fetch(10'h010, 10'h080, 3'b000, 1'b1);
        check("sat_pt", 32'(pred_taken), 32'd1);
        fetch(10'h010, 10'h080, 3'b000, 1'b0);
        check("miss_pt",  32'(pred_taken), 32'd0);
        check("miss_ppc", 32'(pred_pc), 32'h011);
        fetch_off(); #1;
        check("nobr_pt", 32'(pred_taken), 32'd0);
        tick();
        check("nobr_cnt", 32'(queue_count), 32'd0);

        // Mispredict flush with a same-cycle push discarded
        fetch(10'h020, 10'h0A0, 3'b001, 1'b1);
        check("m1_pt", 32'(pred_taken), 32'd0);
        tick();
        fetch(10'h030, 10'h0B0, 3'b001, 1'b1);
        tick();
        check("m_cnt2", 32'(queue_count), 32'd2);
        fetch(10'h040, 10'h0C0, 3'b010, 1'b1);
        resolve(1'b1);
        fetch_off();
        check_retire("m", 10'h020, 1'b1, 1'b1, 10'h0A0);
        check("m_cnt0", 32'(queue_count), 32'd0);
        resolve(1'b1);
        check("empty_we",  32'(cache_we), 32'd0);
        check("empty_mp",  32'(mispredict), 32'd0);
        check("empty_cnt", 32'(queue_count), 32'd0);

        // Fill, then stall a 5th branch during a resolve
        for (int i = 0; i < 4; i++) begin
            fetch(10'h100 + 10'(i), 10'h200, 3'b010, 1'b1);
            tick();
        end
        check("full_cnt", 32'(queue_count), 32'd4);
        fetch(10'h104, 10'h200, 3'b010, 1'b1);
        check("full_stall", 32'(stall), 32'd1);
        resolve(1'b0);
        fetch_off();
        check_retire("q0", 10'h100, 1'b0, 1'b0, 10'h101);
        check("q0_cnt", 32'(queue_count), 32'd3);
        // Simultaneous push and pop keeps the count
        fetch(10'h105, 10'h200, 3'b010, 1'b1);
        resolve(1'b0);
        fetch_off();
        check_retire("q1", 10'h101, 1'b0, 1'b0, 10'h102);
        check("q1_cnt", 32'(queue_count), 32'd3);
        resolve(1'b0);
        check_retire("q2", 10'h102, 1'b0, 1'b0, 10'h103);
        resolve(1'b0);
        check_retire("q3", 10'h103, 1'b0, 1'b0, 10'h104);
        resolve(1'b0);
        check_retire("q4", 10'h105, 1'b0, 1'b0, 10'h106);
        check("q4_cnt", 32'(queue_count), 32'd0);
        resolve(1'b0);
        check("q5_we", 32'(cache_we), 32'd0);

        // PC wrap at the top of the address space
        fetch(10'h3FF, 10'h010, 3'b010, 1'b1);
        check("w_pt",  32'(pred_taken), 32'd0);
        check("w_ppc", 32'(pred_pc), 32'h000);
        tick(); fetch_off();
        resolve(1'b0);
        check("w_we",  32'(cache_we), 32'd1);
        check("w_upc", 32'(cache_update_pc), 32'h3FF);
        check("w_mp",  32'(mispredict), 32'd0);
        check("w_rpc", 32'(redirect_pc), 32'h000);

        // Reset with queued branches and a pending resolve
        for (int i = 0; i < 3; i++) begin
            fetch(10'h050 + 10'(i), 10'h060, 3'b011, 1'b1);
            tick();
        end
        fetch_off();
        check("pre_cnt", 32'(queue_count), 32'd3);
        rst = 1'b1;
        resolve(1'b1);
        rst = 1'b0;
        check("prst_cnt", 32'(queue_count), 32'd0);
        check("prst_we",  32'(cache_we), 32'd0);
        check("prst_mp",  32'(mispredict), 32'd0);
        fetch(10'h010, 10'h080, 3'b000, 1'b1);
        check("prst_pht0", 32'(pred_taken), 32'd0);
        fetch(10'h020, 10'h0A0, 3'b001, 1'b1);
        check("prst_pht1", 32'(pred_taken), 32'd0);
        fetch_off();
        resolve(1'b1);
        check("prst_empty_we", 32'(cache_we), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
